// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_rx -- Philips I2S slave receiver, oversampled in the clk domain.
//
// BCLK, LRCLK and SDATA are synchronised into clk, BCLK rising edges are
// detected, and the stream is deserialised into left/right words (MSB first,
// one-BCLK data delay after each LRCLK change). Each well-formed stereo frame
// produces a one-cycle sample_valid with both words updated on that cycle.
//
// Ports:
//   clk           system clock, at least 4x the BCLK frequency
//   reset_n       asynchronous active-low reset
//   i2s_bclk      external bit clock (asynchronous to clk)
//   i2s_lrclk     external word select, 0 = left, 1 = right
//   i2s_sdata     external serial data
//   sample_valid  one-cycle pulse, samples updated on the same cycle
//   left_sample   last complete left word
//   right_sample  last complete right word
//   locked        high while well-formed frames are being received
//   frame_error   one-cycle pulse on a slot-length violation
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int BITS_PER_SAMPLE = 16,
    parameter int BCLK_PER_LRCLK  = 2 * BITS_PER_SAMPLE,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i2s_bclk,
    input  logic                       i2s_lrclk,
    input  logic                       i2s_sdata,
    output logic                       sample_valid,
    output logic [BITS_PER_SAMPLE-1:0] left_sample,
    output logic [BITS_PER_SAMPLE-1:0] right_sample,
    output logic                       locked,
    output logic                       frame_error
);

    localparam int SLOT_LEN = BCLK_PER_LRCLK / 2;
    localparam int CNT_W    = $clog2(SLOT_LEN + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0]     bclk_sync, lr_sync, sd_sync;
    logic                       bclk_d, bclk_rise;
    logic                       rise_q, lr_s, sd_s, lr_prev, primed;
    logic [CNT_W-1:0]           bit_cnt;
    logic [BITS_PER_SAMPLE-1:0] shreg, left_pend, word_done;
    logic                       left_ok;
    logic                       boundary, slot_ok;
    logic                       emit_pair, emit_err, take_left, drop_left;

    // NOTE: state lives in always_ff with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_d    <= 1'b0;
            rise_q    <= 1'b0;
            lr_s      <= 1'b0;
            sd_s      <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_d    <= bclk_sync[SYNC_STAGES-1];
            rise_q    <= bclk_rise;
            if (bclk_rise) begin
                lr_s <= lr_sync[SYNC_STAGES-1];
                sd_s <= sd_sync[SYNC_STAGES-1];
            end
        end
    end

    assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_d;

    // The very first sampled rise after reset only primes lr_prev; without it
    // a stream that starts inside a right slot would fake a boundary.
    assign boundary = rise_q & primed & (lr_s != lr_prev);
    assign slot_ok  = (bit_cnt == CNT_W'(SLOT_LEN - 1));

    // The bit on the boundary rise is the delayed last bit of the slot that
    // is closing; it still belongs to the word when the slot is no wider
    // than the sample, otherwise it is padding.
    assign word_done = (bit_cnt < CNT_W'(BITS_PER_SAMPLE))
                     ? {shreg[BITS_PER_SAMPLE-2:0], sd_s} : shreg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= HUNT;
        else          state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        emit_pair  = 1'b0;
        emit_err   = 1'b0;
        take_left  = 1'b0;
        drop_left  = 1'b0;
        if (boundary) begin
            case (state)
                HUNT: begin
                    next_state = SYNC;
                    drop_left  = 1'b1;
                end
                SYNC, LOCKED: begin
                    if (!slot_ok) begin
                        emit_err   = 1'b1;
                        drop_left  = 1'b1;
                        next_state = SYNC;
                    end else if (!lr_prev) begin
                        take_left = 1'b1;
                    end else begin
                        drop_left = 1'b1;
                        if (left_ok) begin
                            emit_pair  = 1'b1;
                            next_state = LOCKED;
                        end
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_prev      <= 1'b0;
            primed       <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            left_pend    <= '0;
            left_ok      <= 1'b0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            locked       <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
        end else begin
            sample_valid <= emit_pair;
            frame_error  <= emit_err;
            locked       <= (next_state == LOCKED);

            if (rise_q) begin
                lr_prev <= lr_s;
                primed  <= 1'b1;
                if (boundary) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    if (bit_cnt < CNT_W'(BITS_PER_SAMPLE))
                        shreg <= {shreg[BITS_PER_SAMPLE-2:0], sd_s};
                    if (bit_cnt != CNT_W'(SLOT_LEN))
                        bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            if (take_left) begin
                left_pend <= word_done;
                left_ok   <= 1'b1;
            end
            if (drop_left)
                left_ok <= 1'b0;

            if (emit_pair) begin
                left_sample  <= left_pend;
                right_sample <= word_done;
            end
        end
    end

endmodule
